dht_measure_scheduler: RTL

Sequences the DHT11 sensor interface and the UART report path. It merges start requests from the debounced button, the UART 'r' command and an internal auto-repeat timer. It enforces the sensor's minimum re-trigger gap, times out missing responses and validates the checksum. It then streams the result into the UART TX FIFO under full-flag backpressure and holds the last good reading for the FND display.

---
 rtl/dht_sched_pkg.sv | 21 ++
 rtl/dht_measure_scheduler_tick.sv | 39 +++
 rtl/dht_measure_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dht_sched_pkg.sv
// Shared types, constants and checksum helper for the DHT11 measurement scheduler.
package dht_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_RESP = 3'd2,
      S_SEND      = 3'd3,
      S_GAP       = 3'd4
   } sched_state_e;

   localparam logic [7:0]  ERR_BYTE_DEF = 8'h45;
   localparam int unsigned GOOD_LEN     = 5;
   localparam int unsigned ERR_LEN      = 1;

   // DHT11 frame is {hum_i, hum_d, tmp_i, tmp_d, chk}; chk is the byte sum mod 256.
   function automatic logic [7:0] dht_checksum(input logic [39:0] frame);
      return frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
   endfunction

endpackage

// File: rtl/dht_measure_scheduler_tick.sv
// Millisecond tick generator: one-cycle tick_o every TICK_DIV clocks, restartable.
module ms_tick_gen #(
   parameter int unsigned TICK_DIV = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned   CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   // The clear cycle counts as the first cycle of the new period, so ticks
   // line up with whole milliseconds measured from the clearing event.
   localparam logic [CW-1:0] RESTART = (TICK_DIV > 1) ? ONE : '0;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + ONE;
      if (clr_i) begin
         cnt_d = RESTART;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/dht_measure_scheduler.sv
// Schedules DHT11 measurements: merges requests, enforces re-trigger gap and
// response timeout, validates checksum and streams the result to the UART TX FIFO.
module dht_measure_scheduler
   import dht_sched_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 100_000,
   parameter int unsigned MIN_GAP_MS     = 2000,
   parameter int unsigned TIMEOUT_MS     = 50,
   parameter int unsigned AUTO_PERIOD_MS = 5000,
   parameter logic [7:0]  ERR_BYTE       = ERR_BYTE_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_btn,
   input  logic         req_uart,
   input  logic         auto_en,
   output logic         sensor_start,
   input  logic         sensor_valid,
   input  logic [39:0]  sensor_data,
   input  logic         tx_full,
   output logic         tx_wr,
   output logic [7:0]   tx_data,
   output logic [15:0]  disp_data,
   output logic         busy,
   output logic [7:0]   err_cnt,
   output sched_state_e dbg_state
);

   localparam int unsigned MS_TOP0 = (MIN_GAP_MS > TIMEOUT_MS) ? MIN_GAP_MS : TIMEOUT_MS;
   localparam int unsigned MS_TOP  = (AUTO_PERIOD_MS > MS_TOP0) ? AUTO_PERIOD_MS : MS_TOP0;
   localparam int unsigned MS_W    = $clog2(MS_TOP + 1);

   localparam logic [MS_W-1:0] MS_SAT   = '1;
   localparam logic [MS_W-1:0] MS_ONE   = MS_W'(1);
   localparam logic [MS_W-1:0] GAP_THR  = MS_W'(MIN_GAP_MS);
   localparam logic [MS_W-1:0] TO_THR   = MS_W'(TIMEOUT_MS);
   localparam logic [MS_W-1:0] AUTO_THR = MS_W'(AUTO_PERIOD_MS);

   sched_state_e    state_q, state_d;
   logic            pending_q, pending_d;
   logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
   logic [7:0]      err_cnt_q, err_cnt_d;
   logic [15:0]     disp_q, disp_d;
   logic [39:0]     buf_q, buf_d;
   logic [2:0]      bcnt_q, bcnt_d;
   logic            ovld_q, ovld_d;
   logic [7:0]      obyte_q, obyte_d;
   logic            ms_tick;
   logic            tick_clr;
   logic            fail;
   logic            tx_accept;

   assign tick_clr = (state_q == S_START);

   ms_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clr_i (tick_clr),
      .tick_o(ms_tick)
   );

   // FIFO handshake: a byte is written in exactly the cycles where tx_wr=1, and
   // tx_wr is only raised while tx_full=0; otherwise the staged byte is held.
   assign tx_accept = ovld_q & ~tx_full;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | req_btn | req_uart;
      ms_cnt_d  = ms_cnt_q;
      err_cnt_d = err_cnt_q;
      disp_d    = disp_q;
      buf_d     = buf_q;
      bcnt_d    = bcnt_q;
      ovld_d    = ovld_q;
      obyte_d   = obyte_q;
      fail      = 1'b0;

      if (state_q == S_IDLE && auto_en && ms_cnt_q >= AUTO_THR) begin
         pending_d = 1'b1;
      end

      if (state_q == S_START) begin
         ms_cnt_d = '0;
      end else if (ms_tick && ms_cnt_q != MS_SAT) begin
         ms_cnt_d = ms_cnt_q + MS_ONE;
      end

      case (state_q)
         S_IDLE: begin
            // Requests arriving in this cycle are folded into the measurement being launched.
            if (pending_q) begin
               state_d   = S_START;
               pending_d = 1'b0;
            end
         end
         S_START: begin
            state_d = S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            if (sensor_valid) begin
               if (dht_checksum(sensor_data) == sensor_data[7:0]) begin
                  buf_d   = sensor_data;
                  bcnt_d  = 3'(GOOD_LEN);
                  disp_d  = {sensor_data[39:32], sensor_data[23:16]};
                  state_d = S_SEND;
               end else begin
                  fail = 1'b1;
               end
            end else if (ms_cnt_q >= TO_THR) begin
               fail = 1'b1;
            end
         end
         S_SEND: begin
            // One-byte output stage: refill it whenever it is empty or being written.
            if (!ovld_q || tx_accept) begin
               if (bcnt_q != 3'd0) begin
                  ovld_d  = 1'b1;
                  obyte_d = buf_q[39:32];
                  buf_d   = {buf_q[31:0], 8'h00};
                  bcnt_d  = bcnt_q - 3'd1;
               end else begin
                  ovld_d  = 1'b0;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (ms_cnt_q >= GAP_THR) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (fail) begin
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
         buf_d   = {ERR_BYTE, 32'h0};
         bcnt_d  = 3'(ERR_LEN);
         state_d = S_SEND;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pending_q <= 1'b0;
         ms_cnt_q  <= MS_SAT;
         err_cnt_q <= 8'h00;
         disp_q    <= 16'h0000;
         buf_q     <= 40'h0;
         bcnt_q    <= 3'd0;
         ovld_q    <= 1'b0;
         obyte_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ms_cnt_q  <= ms_cnt_d;
         err_cnt_q <= err_cnt_d;
         disp_q    <= disp_d;
         buf_q     <= buf_d;
         bcnt_q    <= bcnt_d;
         ovld_q    <= ovld_d;
         obyte_q   <= obyte_d;
      end
   end

   assign sensor_start = (state_q == S_START);
   assign busy         = (state_q != S_IDLE);
   assign tx_wr        = tx_accept;
   assign tx_data      = tx_accept ? obyte_q : 8'h00;
   assign disp_data    = disp_q;
   assign err_cnt      = err_cnt_q;
   assign dbg_state    = state_q;

endmodule
